// File: rtl/imu_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// imu_rx_frame_ctrl
//
// Purpose:
//   Frame controller behind the IMU UART receiver. It hunts for the header
//   byte, captures the TYPE byte and eight payload bytes, and checks the
//   trailing SUM byte. SUM is the modulo-256 sum of HEADER, TYPE and D0..D7.
//   A good frame is presented as one parallel word with a single-cycle
//   frame_vld. Checksum and inter-byte timeout errors are flagged as
//   single-cycle pulses.
//
// Configuration macro:
//   IMU_TYPE_FILTER_EN - when defined, a TYPE byte outside 8'h50..8'h5F
//                        silently drops the frame and returns to HUNT.
//
// Ports:
//   sys_clk      in   1   system clock
//   reset_n      in   1   asynchronous active-low reset
//   rx_vld       in   1   one-cycle byte strobe from UART RX
//   rx_data      in   8   received byte, valid with rx_vld
//   frame_vld    out  1   one-cycle pulse for a good frame
//   frame_type   out  8   TYPE byte of the last good frame
//   frame_data   out 64   payload of the last good frame (D0 in [7:0])
//   sum_err      out  1   one-cycle pulse on checksum mismatch
//   timeout_err  out  1   one-cycle pulse on inter-byte timeout
//   frame_cnt    out 16   count of good frames, wraps
//   busy         out  1   high while state is not HUNT
//   state_dbg    out  2   current FSM state (0 HUNT, 1 TYPE, 2 DATA, 3 SUM)
//
// Handshake: the input side is valid-only. A byte is consumed in every cycle
// where rx_vld is high. There is no ready/backpressure, so back-to-back
// bytes on consecutive cycles are always accepted. The outputs are
// single-cycle pulses with no acknowledge.
// -----------------------------------------------------------------------------
module imu_rx_frame_ctrl #(
    parameter int          FRE_SYS_CLK = 100000000,
    parameter int          TIMEOUT_US  = 200,
    parameter logic [7:0]  HEADER      = 8'h55
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        rx_vld,
    input  logic [7:0]  rx_data,
    output logic        frame_vld,
    output logic [7:0]  frame_type,
    output logic [63:0] frame_data,
    output logic        sum_err,
    output logic        timeout_err,
    output logic [15:0] frame_cnt,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    localparam int TIMEOUT_CNT = FRE_SYS_CLK / 1000000 * TIMEOUT_US - 1;
    localparam int CNT_W       = $clog2(TIMEOUT_CNT) + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CNT);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_TYPE = 2'd1,
        ST_DATA = 2'd2,
        ST_SUM  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] tmo_cnt;
    logic [7:0]       acc;
    logic [2:0]       idx;
    logic [7:0]       type_work;
    logic [63:0]      data_work;

    logic             type_ok;
    logic             sum_ok;
    logic             sum_bad;
    logic             timeout_hit;

    assign state_dbg = state;

`ifdef IMU_TYPE_FILTER_EN
    assign type_ok = (rx_data[7:4] == 4'h5);
`else
    assign type_ok = 1'b1;
`endif

    // State register
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A byte arriving in the same cycle as the timeout
    // terminal count takes priority, so the timeout only fires when
    // rx_vld is low.
    always_comb begin
        state_nxt   = state;
        sum_ok      = 1'b0;
        sum_bad     = 1'b0;
        timeout_hit = 1'b0;
        if (rx_vld) begin
            case (state)
                ST_HUNT: if (rx_data == HEADER) state_nxt = ST_TYPE;
                ST_TYPE: state_nxt = type_ok ? ST_DATA : ST_HUNT;
                ST_DATA: if (idx == 3'd7) state_nxt = ST_SUM;
                ST_SUM: begin
                    state_nxt = ST_HUNT;
                    if (rx_data == acc) sum_ok = 1'b1;
                    else                sum_bad = 1'b1;
                end
                default: state_nxt = ST_HUNT;
            endcase
        end else if (state != ST_HUNT && tmo_cnt == TMO_LAST) begin
            state_nxt   = ST_HUNT;
            timeout_hit = 1'b1;
        end
    end

    // Working registers: timeout counter, checksum accumulator, byte index,
    // captured type and payload.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt   <= '0;
            acc       <= 8'd0;
            idx       <= 3'd0;
            type_work <= 8'd0;
            data_work <= 64'd0;
        end else begin
            if (rx_vld || state == ST_HUNT || timeout_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end

            if (rx_vld) begin
                case (state)
                    ST_HUNT: begin
                        if (rx_data == HEADER) acc <= HEADER;
                    end
                    ST_TYPE: begin
                        type_work <= rx_data;
                        acc       <= acc + rx_data;
                        idx       <= 3'd0;
                    end
                    ST_DATA: begin
                        data_work[{idx, 3'b000} +: 8] <= rx_data;
                        acc <= acc + rx_data;
                        idx <= idx + 3'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Registered outputs. frame_type/frame_data only move on a good frame.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_vld   <= 1'b0;
            sum_err     <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            frame_type  <= 8'd0;
            frame_data  <= 64'd0;
            frame_cnt   <= 16'd0;
        end else begin
            frame_vld   <= sum_ok;
            sum_err     <= sum_bad;
            timeout_err <= timeout_hit;
            busy        <= (state_nxt != ST_HUNT);
            if (sum_ok) begin
                frame_type <= type_work;
                frame_data <= data_work;
                frame_cnt  <= frame_cnt + 16'd1;
            end
        end
    end

endmodule
